// File: rtl/ysyx_25060170_imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package ysyx_25060170_imem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } imem_state_e;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;
    localparam logic [31:0] DEF_ERR_DATA  = 32'h0000_0000;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ysyx_25060170_imem_array.sv
// Word storage: synchronous write from the load port, asynchronous read.
module ysyx_25060170_imem_array
    import ysyx_25060170_imem_pkg::*;
#(
    parameter int DEPTH = 4096,
    localparam int IW = idx_width(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] widx,
    input  logic [31:0]   wdata,
    input  logic [IW-1:0] ridx,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/ysyx_25060170_imem_resp.sv
// Instruction-memory responder: fixed-latency word reads over
// valid/ready request and response channels, one request in flight.
module ysyx_25060170_imem_resp
    import ysyx_25060170_imem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int          DEPTH     = 4096,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] ERR_DATA  = DEF_ERR_DATA,
    localparam int         IW        = idx_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_addr,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_data,
    output logic          resp_err,
    input  logic          ld_en,
    input  logic [IW-1:0] ld_idx,
    input  logic [31:0]   ld_data
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    imem_state_e state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] cap_addr;
    logic [31:0] off;
    logic [31:0] rdata;
    logic [31:0] cap_data;
    logic        cap_err;

    assign req_ready = (state == IDLE) && !rst;

    // With LATENCY==1 the capture happens on the accepting edge itself,
    // before addr_q holds the request, so look at req_addr directly.
    assign cap_addr = (state == IDLE) ? req_addr : addr_q;
    assign off      = cap_addr - BASE_ADDR;
    assign cap_err  = (cap_addr[1:0] != 2'b00)
                   || (cap_addr < BASE_ADDR)
                   || ((off >> 2) >= 32'(DEPTH));
    assign cap_data = cap_err ? ERR_DATA : rdata;

    ysyx_25060170_imem_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk  (clk),
        .we   (ld_en),
        .widx (ld_idx),
        .wdata(ld_data),
        .ridx (off[IW+1:2]),
        .rdata(rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr;
                        if (LATENCY == 1) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_data  <= cap_data;
                            resp_err   <= cap_err;
                        end else begin
                            cnt   <= CNT_INIT;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_data  <= cap_data;
                        resp_err   <= cap_err;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25060170_imem_resp.sv
// Bench for the instruction-memory responder: directed corner cases
// plus random traffic against a word-array reference model.
module tb_ysyx_25060170_imem_resp;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 4096;
    localparam int          LAT   = 2;
    localparam logic [31:0] ERRD  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_data;
    logic        ld_en;
    logic [11:0] ld_idx;
    logic [31:0] ld_data;

    logic        req1_valid, req1_ready;
    logic [31:0] req1_addr;
    logic        resp1_valid, resp1_ready, resp1_err;
    logic [31:0] resp1_data;
    logic        ld1_en;
    logic [11:0] ld1_idx;
    logic [31:0] ld1_data;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model [DEPTH];

    always #5 clk = ~clk;

    ysyx_25060170_imem_resp #(
        .BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(LAT), .ERR_DATA(ERRD)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
    );

    ysyx_25060170_imem_resp #(
        .BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(1), .ERR_DATA(ERRD)
    ) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req1_valid), .req_ready(req1_ready), .req_addr(req1_addr),
        .resp_valid(resp1_valid), .resp_ready(resp1_ready),
        .resp_data(resp1_data), .resp_err(resp1_err),
        .ld_en(ld1_en), .ld_idx(ld1_idx), .ld_data(ld1_data)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_err(input logic [31:0] a);
        if (a % 4 != 0) return 1'b1;
        if (a < BASE) return 1'b1;
        return ((a - BASE) / 4) >= 32'(DEPTH);
    endfunction

    task automatic ld(input int idx, input logic [31:0] d);
        ld_en = 1'b1;
        ld_idx = 12'(idx);
        ld_data = d;
        @(posedge clk);
        #1 ld_en = 1'b0;
        model[idx] = d;
    endtask

    // Start at posedge+1 with the DUT idle; return at the negedge where
    // resp_valid is first seen (or the bound expires).
    task automatic issue(input logic [31:0] a, output int lat);
        req_valid = 1'b1;
        req_addr = a;
        resp_ready = 1'b0;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_addr = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            chk("req_ready_busy", 32'(req_ready), 32'd0);
        end while (!resp_valid && lat < 40);
    endtask

    task automatic finish(input int stall, input logic [31:0] d,
                          input logic e);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_data", resp_data, d);
            chk("hold_err", 32'(resp_err), 32'(e));
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        chk("post_valid", 32'(resp_valid), 32'd0);
        chk("post_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic xact(input logic [31:0] a, input int stall);
        int          lat;
        logic        e;
        logic [31:0] d;
        e = exp_err(a);
        d = e ? ERRD : model[int'((a - BASE) >> 2)];
        issue(a, lat);
        chk("latency", 32'(lat), 32'(LAT));
        chk("data", resp_data, d);
        chk("err", 32'(resp_err), 32'(e));
        finish(stall, d, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          acc;
        int          kind;
        logic [31:0] a;
        logic [31:0] oldv;

        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
        ld_en = 1'b0; ld_idx = '0; ld_data = '0;
        req1_valid = 1'b0; req1_addr = '0; resp1_ready = 1'b0;
        ld1_en = 1'b0; ld1_idx = '0; ld1_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;

        ld1_en = 1'b1; ld1_idx = '0; ld1_data = 32'h1234_5678;
        @(posedge clk);
        #1 ld1_en = 1'b0;

        ld(0, 32'h0000_0413);
        xact(BASE, 0);
        xact(BASE + 32'd2, 0);
        xact(32'h7FFF_FFFC, 0);
        xact(32'h8000_4000, 0);
        ld(DEPTH - 1, 32'h0BAD_F00D);
        xact(BASE + 32'h3FFC, 1);

        // Stalled response while the same word is rewritten.
        oldv = model[0];
        issue(BASE, lat);
        chk("stall_latency", 32'(lat), 32'(LAT));
        chk("stall_data0", resp_data, oldv);
        ld_en = 1'b1; ld_idx = '0; ld_data = 32'hCAFE_0001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(resp_valid), 32'd1);
            chk("stall_data", resp_data, oldv);
            chk("stall_err", 32'(resp_err), 32'd0);
        end
        ld_en = 1'b0;
        model[0] = 32'hCAFE_0001;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        chk("stall_release", 32'(resp_valid), 32'd0);
        xact(BASE, 0);

        // Load on the capture edge of the requested word.
        ld(2, 32'h1111_2222);
        req_valid = 1'b1; req_addr = BASE + 32'd8;
        @(posedge clk);
        #1 req_valid = 1'b0;
        ld_en = 1'b1; ld_idx = 12'd2; ld_data = 32'h3333_4444;
        @(negedge clk);
        chk("cap_wait_valid", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1 ld_en = 1'b0;
        @(negedge clk);
        chk("cap_valid", 32'(resp_valid), 32'd1);
        chk("cap_old_data", resp_data, 32'h1111_2222);
        model[2] = 32'h3333_4444;
        finish(0, 32'h1111_2222, 1'b0);
        xact(BASE + 32'd8, 0);

        // Asynchronous reset in WAIT, then in RESP.
        ld(5, 32'h5555_AAAA);
        req_valid = 1'b1; req_addr = BASE + 32'd20;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_wait_ready", 32'(req_ready), 32'd0);
        chk("arst_wait_valid", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("orphan_valid", 32'(resp_valid), 32'd0);
            chk("orphan_ready", 32'(req_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        issue(BASE + 32'd20, lat);
        chk("pre_arst_valid", 32'(resp_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_resp_valid", 32'(resp_valid), 32'd0);
        chk("arst_resp_data", resp_data, 32'd0);
        chk("arst_resp_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("arst_after_valid", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1;
        xact(BASE + 32'd20, 0);

        // LATENCY=1 instance with a requester that never drops valid.
        req1_valid = 1'b1; req1_addr = BASE; resp1_ready = 1'b1;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("l1_ready", 32'(req1_ready), 32'(i % 2 == 0));
            chk("l1_valid", 32'(resp1_valid), 32'(i % 2 == 1));
            if (i % 2 == 1) begin
                chk("l1_data", resp1_data, 32'h1234_5678);
                chk("l1_err", 32'(resp1_err), 32'd0);
            end
            if (req1_ready) acc++;
        end
        req1_valid = 1'b0;
        chk("l1_accepts", 32'(acc), 32'd10);
        @(posedge clk);
        #1;

        // Random traffic.
        for (int i = 0; i < 16; i++) ld(i, $urandom);
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) ld($urandom_range(0, 15), $urandom);
            kind = $urandom_range(0, 5);
            case (kind)
                3: a = BASE + 32'(4 * $urandom_range(0, 15))
                     + 32'($urandom_range(1, 3));
                4: a = BASE - 32'(4 * $urandom_range(1, 4096));
                5: a = BASE + 32'(4 * DEPTH)
                     + 32'(4 * $urandom_range(0, 1000));
                default: a = BASE + 32'(4 * $urandom_range(0, 15));
            endcase
            xact(a, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
